// File: rtl/kaipokrandt_control_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit microcontroller: owns the shared-bus
// schedule and every datapath strobe, and halts on HALT or a memory timeout.
module kaipokrandt_control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       mem_ack,
  output logic [2:0] bus_sel,
  output logic       mar_load,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_load,
  output logic [2:0] alu_op,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_BOOT       = 4'd0,
    S_FETCH_ADDR = 4'd1,
    S_FETCH_MEM  = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC       = 4'd4,
    S_MEM_ADDR   = 4'd5,
    S_MEM_READ   = 4'd6,
    S_MEM_WRITE  = 4'd7,
    S_JUMP       = 4'd8,
    S_HALT       = 4'd9
  } state_t;

  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_PC   = 3'd1;
  localparam logic [2:0] BUS_IR   = 3'd2;
  localparam logic [2:0] BUS_ALU  = 3'd3;
  localparam logic [2:0] BUS_MEM  = 3'd4;
  localparam logic [2:0] BUS_ACC  = 3'd5;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // The error fires on the MEM_TIMEOUT-th consecutive cycle without ack; an ack in that cycle wins.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q;
  logic [3:0] op_q;
  logic       boot_q;
  logic [7:0] wait_cnt;
  logic       mem_err_q;
  logic       waiting;
  logic       timeout;

  // Memory handshake: mem_rd/mem_wr are level requests held until the cycle mem_ack is
  // seen high; mem_ack is only meaningful while one of them is high and ignored otherwise.
  assign waiting = (state_q == S_FETCH_MEM) || (state_q == S_MEM_READ) ||
                   (state_q == S_MEM_WRITE);
  assign timeout = waiting && !mem_ack && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_BOOT;
      op_q      <= OP_NOP;
      boot_q    <= 1'b0;
      wait_cnt  <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      // Idle states hold the counter at zero, so each wait state is entered with a clean count.
      if (waiting && !mem_ack && !timeout) wait_cnt <= wait_cnt + 8'd1;
      else                                 wait_cnt <= 8'd0;
      if (timeout) mem_err_q <= 1'b1;

      case (state_q)
        S_BOOT: begin
          // One extra BOOT cycle after release keeps the first fetch off the release edge.
          boot_q <= 1'b1;
          if (boot_q) state_q <= S_FETCH_ADDR;
        end
        S_FETCH_ADDR: state_q <= S_FETCH_MEM;
        S_FETCH_MEM: begin
          if (mem_ack)      state_q <= S_DECODE;
          else if (timeout) state_q <= S_HALT;
        end
        S_DECODE: begin
          op_q <= opcode;
          case (opcode)
            OP_NOP:                                 state_q <= S_FETCH_ADDR;
            OP_LOAD, OP_STORE:                      state_q <= S_MEM_ADDR;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT:  state_q <= S_EXEC;
            OP_JMP:                                 state_q <= S_JUMP;
            OP_JZ:   state_q <= zero_flag ? S_JUMP : S_FETCH_ADDR;
            OP_HALT:                                state_q <= S_HALT;
            default:                                state_q <= S_FETCH_ADDR;
          endcase
        end
        S_EXEC:     state_q <= S_FETCH_ADDR;
        S_MEM_ADDR: state_q <= (op_q == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ, S_MEM_WRITE: begin
          if (mem_ack)      state_q <= S_FETCH_ADDR;
          else if (timeout) state_q <= S_HALT;
        end
        S_JUMP:     state_q <= S_FETCH_ADDR;
        S_HALT:     state_q <= S_HALT;
        default:    state_q <= S_BOOT;
      endcase
    end
  end

  // Strobes decode from the registered state; ir_load/pc_inc/acc_load also follow mem_ack.
  always_comb begin
    bus_sel  = BUS_NONE;
    mar_load = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    acc_load = 1'b0;
    alu_op   = 3'd0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH_ADDR: begin
        bus_sel  = BUS_PC;
        mar_load = 1'b1;
      end
      S_FETCH_MEM: begin
        bus_sel = BUS_MEM;
        mem_rd  = 1'b1;
        ir_load = mem_ack;
        pc_inc  = mem_ack;
      end
      S_DECODE: illegal = (opcode >= 4'hA) && (opcode <= 4'hE);
      S_EXEC: begin
        bus_sel  = BUS_ALU;
        acc_load = 1'b1;
        alu_op   = 3'(op_q - OP_ADD);
      end
      S_MEM_ADDR: begin
        bus_sel  = BUS_IR;
        mar_load = 1'b1;
      end
      S_MEM_READ: begin
        bus_sel  = BUS_MEM;
        mem_rd   = 1'b1;
        acc_load = mem_ack;
      end
      S_MEM_WRITE: begin
        bus_sel = BUS_ACC;
        mem_wr  = 1'b1;
      end
      S_JUMP: begin
        bus_sel = BUS_IR;
        pc_load = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign mem_err = mem_err_q;
  assign state   = state_q;

  a_rd_wr_excl: assert property (@(posedge clk) disable iff (reset) !(mem_rd && mem_wr));
  a_pc_excl:    assert property (@(posedge clk) disable iff (reset) !(pc_inc && pc_load));

endmodule

// File: tb/tb_kaipokrandt_control_sequencer.sv
// Bench for kaipokrandt_control_sequencer: directed vector table, hand-written corner
// sequences, and random programs checked against an instruction-level reference model.
module tb_kaipokrandt_control_sequencer;

  localparam int T = 4;
  localparam int W = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       zero_flag = 1'b0;
  logic       mem_ack = 1'b0;
  logic [2:0] bus_sel;
  logic       mar_load, ir_load, pc_inc, pc_load, acc_load;
  logic [2:0] alu_op;
  logic       mem_rd, mem_wr, halted, illegal, mem_err;
  logic [3:0] state;
  logic [W-1:0] act;

  typedef struct {
    logic         ack;
    logic [3:0]   op;
    logic         zf;
    logic [W-1:0] exp;
  } vec_t;

  typedef struct {
    logic       ack;
    logic [3:0] op;
    logic       zf;
  } in_t;

  in_t          stim_q[$];
  logic [W-1:0] exp_q[$];
  logic [3:0]   cur_op;
  int           n_cmp = 0;
  int           n_bad = 0;

  kaipokrandt_control_sequencer #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero_flag(zero_flag), .mem_ack(mem_ack),
    .bus_sel(bus_sel), .mar_load(mar_load), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .acc_load(acc_load), .alu_op(alu_op), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .halted(halted), .illegal(illegal), .mem_err(mem_err), .state(state)
  );

  assign act = {state, bus_sel, mar_load, ir_load, pc_inc, pc_load, acc_load, alu_op,
                mem_rd, mem_wr, halted, illegal, mem_err};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input int st, input int bus,
                                      input bit mar, input bit ir, input bit inc,
                                      input bit ld, input bit acc, input int alu,
                                      input bit rd, input bit wr, input bit ill, input bit err);
    return {4'(st), 3'(bus), mar, ir, inc, ld, acc, 3'(alu), rd, wr, (st == 9), ill, err};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input logic [W-1:0] a, input logic [W-1:0] e, input string tag);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, a, e);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, sample the outputs 1 ns later.
  task automatic apply_cycle(input logic a, input logic [3:0] o, input logic z,
                             input logic [W-1:0] e, input string tag);
    @(negedge clk);
    mem_ack   = a;
    opcode    = o;
    zero_flag = z;
    #1;
    check(act, e, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    mem_ack   = 1'b0;
    zero_flag = 1'b0;
    #1;
    check(act, '0, "reset_vals");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic void push(input logic a, input logic [3:0] o, input logic z,
                               input logic [W-1:0] e);
    in_t s;
    s.ack = a;
    s.op  = o;
    s.zf  = z;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  // Expands one instruction into its cycles: fw/mw are no-ack cycles before the ack
  // in the fetch and data memory phases (always below T, so no timeout occurs).
  function automatic void gen_instr(input logic [3:0] op, input logic zf,
                                    input int fw, input int mw);
    int st;
    int bus;
    bit rd;
    push(rb(), cur_op, rb(), mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (fw) push(1'b0, cur_op, rb(), mk(2, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    push(1'b1, cur_op, rb(), mk(2, 4, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    cur_op = op;
    push(rb(), op, zf, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, (op >= 4'hA && op <= 4'hE), 0));
    if (op >= 4'h3 && op <= 4'h7) begin
      push(rb(), op, rb(), mk(4, 3, 0, 0, 0, 0, 1, int'(op) - 3, 0, 0, 0, 0));
    end else if (op == 4'h1 || op == 4'h2) begin
      rd  = (op == 4'h1);
      st  = rd ? 6 : 7;
      bus = rd ? 4 : 5;
      push(rb(), op, rb(), mk(5, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (mw) push(1'b0, op, rb(), mk(st, bus, 0, 0, 0, 0, 0, 0, rd, !rd, 0, 0));
      push(1'b1, op, rb(), mk(st, bus, 0, 0, 0, 0, rd, 0, rd, !rd, 0, 0));
    end else if (op == 4'h8 || (op == 4'h9 && zf)) begin
      push(rb(), op, rb(), mk(8, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    end else if (op == 4'hF) begin
      repeat (3) push(rb(), op, rb(), mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, T - 1)) : 0;
  endfunction

  // ---------------- test ----------------
  logic [W-1:0] v_boot, v_fa, v_fmw, v_fma, v_dec, v_ill, v_add, v_ma;
  logic [W-1:0] v_mrw, v_mra, v_mww, v_jmp, v_halt, v_herr;
  vec_t         tab[14];
  in_t          s;
  int           n_ins;

  initial begin
    v_boot = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_fa   = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_fmw  = mk(2, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    v_fma  = mk(2, 4, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    v_dec  = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_ill  = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    v_add  = mk(4, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    v_ma   = mk(5, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_mrw  = mk(6, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    v_mra  = mk(6, 4, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    v_mww  = mk(7, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    v_jmp  = mk(8, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    v_halt = mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v_herr = mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Program NOP, ADD, HALT with immediate ack; stray acks outside memory states are ignored.
    tab[0]  = '{1'b0, 4'h0, 1'b0, v_boot};
    tab[1]  = '{1'b1, 4'h0, 1'b0, v_fa};
    tab[2]  = '{1'b1, 4'h0, 1'b0, v_fma};
    tab[3]  = '{1'b1, 4'h0, 1'b1, v_dec};
    tab[4]  = '{1'b0, 4'h0, 1'b0, v_fa};
    tab[5]  = '{1'b1, 4'h0, 1'b0, v_fma};
    tab[6]  = '{1'b0, 4'h3, 1'b0, v_dec};
    tab[7]  = '{1'b1, 4'h3, 1'b1, v_add};
    tab[8]  = '{1'b0, 4'h3, 1'b0, v_fa};
    tab[9]  = '{1'b1, 4'h3, 1'b0, v_fma};
    tab[10] = '{1'b0, 4'hF, 1'b0, v_dec};
    tab[11] = '{1'b1, 4'hF, 1'b0, v_halt};
    tab[12] = '{1'b1, 4'h0, 1'b1, v_halt};
    tab[13] = '{1'b0, 4'h8, 1'b0, v_halt};

    do_reset();
    for (int i = 0; i < 14; i++)
      apply_cycle(tab[i].ack, tab[i].op, tab[i].zf, tab[i].exp, $sformatf("table[%0d]", i));

    // LOAD with three wait cycles in MEM_READ: eight cycles, acc_load only with the ack.
    do_reset();
    apply_cycle(1'b0, 4'h0, 1'b0, v_boot, "load_boot");
    apply_cycle(1'b0, 4'h0, 1'b0, v_fa,   "load_fa");
    apply_cycle(1'b1, 4'h0, 1'b0, v_fma,  "load_fm");
    apply_cycle(1'b0, 4'h1, 1'b0, v_dec,  "load_dec");
    apply_cycle(1'b1, 4'h1, 1'b0, v_ma,   "load_ma");
    for (int i = 0; i < 3; i++) apply_cycle(1'b0, 4'h1, 1'b0, v_mrw, "load_wait");
    apply_cycle(1'b1, 4'h1, 1'b0, v_mra,  "load_ack");
    apply_cycle(1'b0, 4'h1, 1'b0, v_fa,   "load_next");

    // JZ not taken, then JZ taken.
    do_reset();
    apply_cycle(1'b0, 4'h0, 1'b1, v_boot, "jz_boot");
    apply_cycle(1'b0, 4'h0, 1'b1, v_fa,   "jz_fa");
    apply_cycle(1'b1, 4'h0, 1'b1, v_fma,  "jz_fm");
    apply_cycle(1'b0, 4'h9, 1'b0, v_dec,  "jz0_dec");
    apply_cycle(1'b0, 4'h9, 1'b1, v_fa,   "jz0_fa");
    apply_cycle(1'b1, 4'h9, 1'b0, v_fma,  "jz1_fm");
    apply_cycle(1'b0, 4'h9, 1'b1, v_dec,  "jz1_dec");
    apply_cycle(1'b0, 4'h9, 1'b0, v_jmp,  "jz1_jump");
    apply_cycle(1'b0, 4'h9, 1'b0, v_fa,   "jz1_fa");

    // Reserved opcode 0xB: one illegal pulse, then fetch resumes.
    do_reset();
    apply_cycle(1'b0, 4'h0, 1'b0, v_boot, "ill_boot");
    apply_cycle(1'b0, 4'h0, 1'b0, v_fa,   "ill_fa");
    apply_cycle(1'b1, 4'h0, 1'b0, v_fma,  "ill_fm");
    apply_cycle(1'b0, 4'hB, 1'b0, v_ill,  "ill_dec");
    apply_cycle(1'b0, 4'hB, 1'b0, v_fa,   "ill_fa2");
    apply_cycle(1'b1, 4'hB, 1'b0, v_fma,  "ill_fm2");
    apply_cycle(1'b0, 4'h0, 1'b0, v_dec,  "ill_dec2");

    // Fetch timeout: four no-ack cycles raise mem_err and HALT, and both stick.
    do_reset();
    apply_cycle(1'b0, 4'h0, 1'b0, v_boot, "to_boot");
    apply_cycle(1'b0, 4'h0, 1'b0, v_fa,   "to_fa");
    for (int i = 0; i < T; i++) apply_cycle(1'b0, 4'h0, 1'b0, v_fmw, "to_wait");
    apply_cycle(1'b1, 4'h0, 1'b0, v_herr, "to_halt");
    apply_cycle(1'b1, 4'h0, 1'b0, v_herr, "to_sticky");

    // Ack on the fourth wait cycle wins over the timeout.
    do_reset();
    apply_cycle(1'b0, 4'h0, 1'b0, v_boot, "aw_boot");
    apply_cycle(1'b0, 4'h0, 1'b0, v_fa,   "aw_fa");
    for (int i = 0; i < T - 1; i++) apply_cycle(1'b0, 4'h0, 1'b0, v_fmw, "aw_wait");
    apply_cycle(1'b1, 4'h0, 1'b0, v_fma,  "aw_ack");
    apply_cycle(1'b0, 4'h0, 1'b0, v_dec,  "aw_dec");
    apply_cycle(1'b0, 4'h0, 1'b0, v_fa,   "aw_fa2");

    // Reset during a MEM_WRITE wait drops mem_wr without a clock edge.
    do_reset();
    apply_cycle(1'b0, 4'h0, 1'b0, v_boot, "rw_boot");
    apply_cycle(1'b0, 4'h0, 1'b0, v_fa,   "rw_fa");
    apply_cycle(1'b1, 4'h0, 1'b0, v_fma,  "rw_fm");
    apply_cycle(1'b0, 4'h2, 1'b0, v_dec,  "rw_dec");
    apply_cycle(1'b0, 4'h2, 1'b0, v_ma,   "rw_ma");
    apply_cycle(1'b0, 4'h2, 1'b0, v_mww,  "rw_wait1");
    apply_cycle(1'b0, 4'h2, 1'b0, v_mww,  "rw_wait2");
    #2 reset = 1'b1;
    #1 check(act, '0, "rw_async_reset");
    do_reset();
    apply_cycle(1'b0, 4'h2, 1'b0, v_boot, "rw_boot2");
    apply_cycle(1'b0, 4'h2, 1'b0, v_fa,   "rw_fa2");
    apply_cycle(1'b1, 4'h2, 1'b0, v_fma,  "rw_fm2");
    apply_cycle(1'b0, 4'h0, 1'b0, v_dec,  "rw_dec2");

    // Random programs against the instruction-level model.
    for (int p = 0; p < 12; p++) begin
      do_reset();
      cur_op = 4'($urandom_range(0, 15));
      push(rb(), cur_op, rb(), v_boot);
      n_ins = int'($urandom_range(5, 20));
      for (int k = 0; k < n_ins; k++)
        gen_instr(4'($urandom_range(0, 14)), rb(), rand_wait(), rand_wait());
      gen_instr(4'hF, rb(), rand_wait(), 0);
      while (stim_q.size() > 0) begin
        s = stim_q.pop_front();
        apply_cycle(s.ack, s.op, s.zf, exp_q.pop_front(), $sformatf("rand p%0d", p));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kaipokrandt_control_sequencer.md
# kaipokrandt_control_sequencer

Fetch/decode/execute sequencer for the 16-bit microcontroller. It reads the 4-bit opcode from the instruction register and drives every datapath strobe: bus source select, MAR/IR/PC/accumulator loads, ALU op and memory read/write handshakes. It sits beside the IR and PC, owns the shared system bus schedule, and halts on a HALT opcode or a memory timeout.

## Interface
- MEM_TIMEOUT, 255: memory wait cycles tolerated without `mem_ack` before the sequencer raises `mem_err`. Range 1–255; the counter is 8 bits.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset. Forces BOOT immediately.
- opcode  in  4  IR[15:12]. Sampled only in DECODE.
- zero_flag  in  1  accumulator-zero flag. Sampled only in DECODE.
- mem_ack  in  1  memory completion. Valid only while `mem_rd` or `mem_wr` is high; ignored otherwise.
- bus_sel  out  3  bus driver select: 0 none, 1 PC, 2 IR operand (param2), 3 ALU result, 4 memory data, 5 accumulator.
- mar_load  out  1  load MAR from bus.
- ir_load  out  1  load IR from bus.
- pc_inc  out  1  PC += 1.
- pc_load  out  1  load PC from bus.
- acc_load  out  1  load accumulator from bus.
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT. Driven as 0 outside EXEC.
- mem_rd / mem_wr  out  1 each  memory request, level, held until ack.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on a reserved opcode.
- mem_err  out  1  sticky; set by timeout, cleared only by reset.
- state  out  4  debug encoding: BOOT 0, FETCH_ADDR 1, FETCH_MEM 2, DECODE 3, EXEC 4, MEM_ADDR 5, MEM_READ 6, MEM_WRITE 7, JUMP 8, HALT 9.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LOAD: ACC ← mem[param2].
  - 2 STORE: mem[param2] ← ACC.
  - 3 ADD, 4 SUB, 5 AND, 6 OR, 7 NOT: ACC ← ALU result.
  - 8 JMP: PC ← param2.
  - 9 JZ: jump if `zero_flag`.
  - A–E reserved.
  - F HALT.
- BOOT: all outputs 0; goes unconditionally to FETCH_ADDR.
- FETCH_ADDR: `bus_sel`=1, `mar_load`=1 → FETCH_MEM.
- FETCH_MEM: `mem_rd`=1, `bus_sel`=4.
  - On the cycle `mem_ack`=1: `ir_load`=1 and `pc_inc`=1 (Mealy on `mem_ack`) → DECODE.
  - Otherwise stay.
- DECODE: all strobes 0. Next state by opcode:
  - 0 → FETCH_ADDR.
  - 1, 2 → MEM_ADDR.
  - 3–7 → EXEC.
  - 8 → JUMP.
  - 9 → JUMP if `zero_flag`=1, else FETCH_ADDR.
  - A–E → `illegal`=1 for this cycle, then FETCH_ADDR (executed as NOP).
  - F → HALT.
- EXEC: `bus_sel`=3, `alu_op` from opcode (3→0, 4→1, 5→2, 6→3, 7→4), `acc_load`=1 → FETCH_ADDR.
- MEM_ADDR: `bus_sel`=2, `mar_load`=1 → MEM_READ (LOAD) or MEM_WRITE (STORE). Opcode is held stable by the IR.
- MEM_READ: `mem_rd`=1, `bus_sel`=4. On `mem_ack`: `acc_load`=1 → FETCH_ADDR.
- MEM_WRITE: `mem_wr`=1, `bus_sel`=5. On `mem_ack` → FETCH_ADDR.
- JUMP: `bus_sel`=2, `pc_load`=1 → FETCH_ADDR.
- HALT: `halted`=1, all strobes 0. Terminal until reset.
- Wait counter:
  - Clears on entry to FETCH_MEM, MEM_READ and MEM_WRITE.
  - Increments each cycle in those states without `mem_ack`.
  - When the count reaches MEM_TIMEOUT with no ack: `mem_err` is set → HALT.
  - If `mem_ack` arrives in the same cycle the count reaches MEM_TIMEOUT, the ack wins and no error is raised.
- `mem_rd` and `mem_wr` are never high together. `pc_inc` and `pc_load` are never high together.

## Timing
- Reset values: state BOOT; every output 0; `mem_err` 0; counter 0.
- Reset asserted mid-operation aborts immediately, including a pending memory request (`mem_rd`/`mem_wr` drop asynchronously).
- First FETCH_ADDR is the second rising edge after reset deasserts.
- Cycle counts with zero-wait memory (ack on the first request cycle):
  - NOP / JZ not taken / illegal: 3 cycles (FETCH_ADDR, FETCH_MEM, DECODE).
  - ALU op: 4.
  - JMP / JZ taken: 4.
  - LOAD / STORE: 5.
- Each memory wait cycle adds 1.
- `opcode` must be valid the cycle after `ir_load`, which is the DECODE cycle.

## Test plan
- Reset, then program NOP, ADD, HALT with immediate ack → states 0,1,2,3,1,2,3,4,1,2,3,9. `acc_load` once with `alu_op`=0. `halted`=1 from cycle 12 and held.
- LOAD with ack delayed 3 cycles in MEM_READ → `mem_rd` high for 4 cycles. `acc_load` only in the ack cycle. Instruction takes 8 cycles.
- JZ with `zero_flag`=0, then JZ with `zero_flag`=1 → first returns to FETCH_ADDR with no `pc_load`; second yields one `pc_load` with `bus_sel`=2.
- Opcode 0xB → one `illegal` pulse in DECODE, no strobes, fetch resumes.
- MEM_TIMEOUT=4 with `mem_ack` held 0 in FETCH_MEM → `mem_err` and `halted` both 1 after 4 wait cycles. Separately, ack arriving on the 4th wait cycle → no error.
- Reset asserted during MEM_WRITE wait → `mem_wr` drops without a clock edge, state=0, then a normal fetch follows.
